// File: rtl/skew_feeder.sv
// Skews row/column operand vectors into a systolic array and sequences its control.
// Optional beat counter output is enabled by defining SKEW_FEEDER_BEAT_COUNT_EN.
module skew_feeder #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*DATA_WIDTH-1:0] in_a,
  input  logic [N*DATA_WIDTH-1:0] in_b,
  input  logic                    in_last,
  output logic [N*DATA_WIDTH-1:0] left_out,
  output logic [N*DATA_WIDTH-1:0] top_out,
  output logic                    shift_en,
  output logic                    acc_en,
  output logic                    acc_rst,
  output logic                    tile_done
`ifdef SKEW_FEEDER_BEAT_COUNT_EN
  ,
  output logic [15:0]             beat_count
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } state_e;

  localparam int DRAIN_LEN = 2 * N - 2;
  localparam int CW        = $clog2(2 * N);

  state_e          state_q, state_d;
  logic [CW-1:0]   drain_cnt_q, drain_cnt_d;
  logic            in_ready_q, in_ready_d;
  logic            shift_en_q, shift_en_d;
  logic            acc_en_q, acc_en_d;
  logic            acc_rst_q, acc_rst_d;
  logic            tile_done_q, tile_done_d;

  logic                    handshake;
  logic                    advance;
  logic                    clear_lines;
  logic [N*DATA_WIDTH-1:0] inject_a;
  logic [N*DATA_WIDTH-1:0] inject_b;

  // in_ready_q is high exactly while in FEED, so it doubles as the FEED qualifier
  always_comb begin
    handshake   = in_valid & in_ready_q;
    advance     = handshake | (state_q == DRAIN);
    clear_lines = (state_d == CLEAR);
    inject_a    = (state_q == DRAIN) ? '0 : in_a;
    inject_b    = (state_q == DRAIN) ? '0 : in_b;
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = '0;
    case (state_q)
      IDLE: begin
        if (in_valid) state_d = CLEAR;
      end
      CLEAR: begin
        state_d = FEED;
      end
      FEED: begin
        if (handshake && in_last) state_d = (N == 1) ? DONE : DRAIN;
      end
      DRAIN: begin
        drain_cnt_d = drain_cnt_q + CW'(1);
        if (drain_cnt_q == CW'(DRAIN_LEN - 1)) begin
          state_d     = DONE;
          drain_cnt_d = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control outputs are registered off the next state so they line up with it
  always_comb begin
    in_ready_d  = (state_d == FEED);
    acc_rst_d   = (state_d == CLEAR);
    tile_done_d = (state_d == DONE);
    shift_en_d  = advance;
    acc_en_d    = advance;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      drain_cnt_q <= '0;
      in_ready_q  <= 1'b0;
      shift_en_q  <= 1'b0;
      acc_en_q    <= 1'b0;
      acc_rst_q   <= 1'b0;
      tile_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      in_ready_q  <= in_ready_d;
      shift_en_q  <= shift_en_d;
      acc_en_q    <= acc_en_d;
      acc_rst_q   <= acc_rst_d;
      tile_done_q <= tile_done_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign shift_en  = shift_en_q;
  assign acc_en    = acc_en_q;
  assign acc_rst   = acc_rst_q;
  assign tile_done = tile_done_q;

  // Lane i keeps i+1 stages; the last stage is the registered lane output
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] a_line_q [0:i];
    logic [DATA_WIDTH-1:0] a_line_d [0:i];
    logic [DATA_WIDTH-1:0] b_line_q [0:i];
    logic [DATA_WIDTH-1:0] b_line_d [0:i];

    always_comb begin
      a_line_d = a_line_q;
      b_line_d = b_line_q;
      if (clear_lines) begin
        for (int j = 0; j <= i; j++) begin
          a_line_d[j] = '0;
          b_line_d[j] = '0;
        end
      end else if (advance) begin
        a_line_d[0] = inject_a[i*DATA_WIDTH +: DATA_WIDTH];
        b_line_d[0] = inject_b[i*DATA_WIDTH +: DATA_WIDTH];
        for (int j = 1; j <= i; j++) begin
          a_line_d[j] = a_line_q[j-1];
          b_line_d[j] = b_line_q[j-1];
        end
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int j = 0; j <= i; j++) begin
          a_line_q[j] <= '0;
          b_line_q[j] <= '0;
        end
      end else begin
        a_line_q <= a_line_d;
        b_line_q <= b_line_d;
      end
    end

    assign left_out[i*DATA_WIDTH +: DATA_WIDTH] = a_line_q[i];
    assign top_out[i*DATA_WIDTH +: DATA_WIDTH]  = b_line_q[i];
  end

`ifdef SKEW_FEEDER_BEAT_COUNT_EN
  logic [15:0] beat_count_q, beat_count_d;

  always_comb begin
    beat_count_d = beat_count_q;
    if (state_d == CLEAR) begin
      beat_count_d = '0;
    end else if (handshake && (beat_count_q != 16'hFFFF)) begin
      beat_count_d = beat_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_count_q <= '0;
    end else begin
      beat_count_q <= beat_count_d;
    end
  end

  assign beat_count = beat_count_q;
`endif

endmodule

// File: tb/tb_skew_feeder.sv
// Directed testbench for skew_feeder: an N=4 instance for tile sequencing and an N=1 instance.
module tb_skew_feeder;

  localparam int NL = 4;
  localparam int DW = 8;
  localparam int VW = NL * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_last, in_ready;
  logic [VW-1:0] in_a, in_b, left_out, top_out;
  logic          shift_en, acc_en, acc_rst, tile_done;
  logic          in_valid1, in_last1, in_ready1;
  logic [DW-1:0] in_a1, in_b1, left_out1, top_out1;
  logic          shift_en1, acc_en1, acc_rst1, tile_done1;
`ifdef SKEW_FEEDER_BEAT_COUNT_EN
  logic [15:0]   beat_count, beat_count1;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  skew_feeder #(.N(NL), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .left_out(left_out), .top_out(top_out),
    .shift_en(shift_en), .acc_en(acc_en), .acc_rst(acc_rst), .tile_done(tile_done)
`ifdef SKEW_FEEDER_BEAT_COUNT_EN
    , .beat_count(beat_count)
`endif
  );

  skew_feeder #(.N(1), .DATA_WIDTH(DW)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .in_last(in_last1),
    .left_out(left_out1), .top_out(top_out1),
    .shift_en(shift_en1), .acc_en(acc_en1), .acc_rst(acc_rst1), .tile_done(tile_done1)
`ifdef SKEW_FEEDER_BEAT_COUNT_EN
    , .beat_count(beat_count1)
`endif
  );

  // Lane i of beat k: row data 16k+i, column data 0x80+16k+i
  function automatic logic [DW-1:0] lane_val(input int beat, input int i, input bit is_b);
    return is_b ? 8'(128 + 16 * beat + i) : 8'(16 * beat + i);
  endfunction

  function automatic logic [VW-1:0] beat_vec(input int beat, input bit is_b);
    logic [VW-1:0] v;
    for (int i = 0; i < NL; i++) v[i*DW +: DW] = lane_val(beat, i, is_b);
    return v;
  endfunction

  // Expected skewed vector after advance k of a tile with nb beats numbered from off
  function automatic logic [VW-1:0] exp_vec(input int k, input int nb, input int off, input bit is_b);
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < NL; i++) begin
      if ((k - i >= 0) && (k - i < nb)) v[i*DW +: DW] = lane_val(k - i + off, i, is_b);
    end
    return v;
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic test_reset;
    logic [4:0] ctrl_exp;
    repeat (2) @(negedge clk);
    vectors++;
    if ({in_ready, acc_rst, shift_en, acc_en, tile_done, left_out, top_out} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_state dut: ctrl=%b left=%h top=%h expected all zero",
               {in_ready, acc_rst, shift_en, acc_en, tile_done}, left_out, top_out);
    end
    vectors++;
    if ({in_ready1, acc_rst1, shift_en1, acc_en1, tile_done1, left_out1, top_out1} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_state dut1: ctrl=%b left=%h top=%h expected all zero",
               {in_ready1, acc_rst1, shift_en1, acc_en1, tile_done1}, left_out1, top_out1);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 8; c++) begin
      in_valid = (c <= 5);
      in_last  = (c == 5);
      in_a     = beat_vec(clampi(c - 2, 0, 3), 1'b0);
      in_b     = beat_vec(clampi(c - 2, 0, 3), 1'b1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    vectors++;
    if (shift_en !== 1'b1 || left_out !== exp_vec(5, 4, 0, 1'b0)) begin
      miscompares++;
      $display("[TB] FAIL pre_reset_drain: shift_en=%b left=%h expected 1 %h",
               shift_en, left_out, exp_vec(5, 4, 0, 1'b0));
    end
    rst = 1'b0;
    #1;
    ctrl_exp = {in_ready, acc_rst, shift_en, acc_en, tile_done};
    vectors++;
    if (ctrl_exp !== 5'b0 || left_out !== '0 || top_out !== '0) begin
      miscompares++;
      $display("[TB] FAIL mid_drain_reset: ctrl=%b left=%h top=%h expected all zero",
               ctrl_exp, left_out, top_out);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      vectors++;
      if ({in_ready, acc_rst, shift_en, acc_en, tile_done} !== 5'b0) begin
        miscompares++;
        $display("[TB] FAIL abandoned_tile c=%0d: ctrl=%b expected 00000",
                 c, {in_ready, acc_rst, shift_en, acc_en, tile_done});
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_gapless;
    logic [4:0]    ctrl_exp;
    logic [VW-1:0] a_exp, b_exp;
    int            k;
    for (int c = 0; c < 15; c++) begin
      in_valid = (c <= 5);
      in_last  = (c == 5);
      in_a     = (c <= 5) ? beat_vec(clampi(c - 2, 0, 3), 1'b0) : {VW{1'b1}};
      in_b     = (c <= 5) ? beat_vec(clampi(c - 2, 0, 3), 1'b1) : {VW{1'b1}};
      @(negedge clk);
      ctrl_exp = {(c >= 2 && c <= 5), (c == 1), (c >= 3 && c <= 12), (c >= 3 && c <= 12), (c == 12)};
      k        = clampi(c - 2, 0, 10) - 1;
      a_exp    = exp_vec(k, 4, 0, 1'b0);
      b_exp    = exp_vec(k, 4, 0, 1'b1);
      vectors++;
      if ({in_ready, acc_rst, shift_en, acc_en, tile_done} !== ctrl_exp) begin
        miscompares++;
        $display("[TB] FAIL gapless_ctrl c=%0d: got %b expected %b",
                 c, {in_ready, acc_rst, shift_en, acc_en, tile_done}, ctrl_exp);
      end
      vectors++;
      if (left_out !== a_exp || top_out !== b_exp) begin
        miscompares++;
        $display("[TB] FAIL gapless_lanes c=%0d: left=%h top=%h expected %h %h",
                 c, left_out, top_out, a_exp, b_exp);
      end
      if (c == 9) begin
        vectors++;
        if (left_out[31:24] !== 8'h33) begin
          miscompares++;
          $display("[TB] FAIL gapless_lane3_c9: got %h expected 33", left_out[31:24]);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_bubble;
    logic [4:0]    ctrl_exp;
    logic [VW-1:0] a_exp, b_exp;
    int            k;
    int            beat;
    for (int c = 0; c < 16; c++) begin
      beat     = (c <= 2) ? 0 : c - 3;
      in_valid = (c <= 6) && (c != 3);
      in_last  = (c == 6);
      in_a     = in_valid ? beat_vec(beat, 1'b0) : {VW{1'b1}};
      in_b     = in_valid ? beat_vec(beat, 1'b1) : {VW{1'b1}};
      @(negedge clk);
      ctrl_exp = {(c >= 2 && c <= 6), (c == 1), (c == 3 || (c >= 5 && c <= 13)),
                  (c == 3 || (c >= 5 && c <= 13)), (c == 13)};
      k        = ((c <= 2) ? 0 : ((c <= 4) ? 1 : clampi(c - 3, 0, 10))) - 1;
      a_exp    = exp_vec(k, 4, 0, 1'b0);
      b_exp    = exp_vec(k, 4, 0, 1'b1);
      vectors++;
      if ({in_ready, acc_rst, shift_en, acc_en, tile_done} !== ctrl_exp) begin
        miscompares++;
        $display("[TB] FAIL bubble_ctrl c=%0d: got %b expected %b",
                 c, {in_ready, acc_rst, shift_en, acc_en, tile_done}, ctrl_exp);
      end
      vectors++;
      if (left_out !== a_exp || top_out !== b_exp) begin
        miscompares++;
        $display("[TB] FAIL bubble_lanes c=%0d: left=%h top=%h expected %h %h",
                 c, left_out, top_out, a_exp, b_exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back;
    logic [4:0]    ctrl_exp;
    logic [VW-1:0] a_exp, b_exp;
    int            beat;
    for (int c = 0; c < 26; c++) begin
      beat     = (c <= 5) ? clampi(c - 2, 0, 3) : 5 + clampi(c - 15, 0, 1);
      in_valid = (c <= 16);
      in_last  = (c == 5) || (c == 16);
      in_a     = beat_vec(beat, 1'b0);
      in_b     = beat_vec(beat, 1'b1);
      @(negedge clk);
      ctrl_exp = {((c >= 2 && c <= 5) || (c >= 15 && c <= 16)), (c == 1 || c == 14),
                  ((c >= 3 && c <= 12) || (c >= 16 && c <= 23)),
                  ((c >= 3 && c <= 12) || (c >= 16 && c <= 23)), (c == 12 || c == 23)};
      if (c <= 14) begin
        a_exp = exp_vec(clampi(c - 2, 0, 10) - 1, 4, 0, 1'b0);
        b_exp = exp_vec(clampi(c - 2, 0, 10) - 1, 4, 0, 1'b1);
      end else begin
        a_exp = exp_vec(clampi(c - 15, 0, 8) - 1, 2, 5, 1'b0);
        b_exp = exp_vec(clampi(c - 15, 0, 8) - 1, 2, 5, 1'b1);
      end
      vectors++;
      if ({in_ready, acc_rst, shift_en, acc_en, tile_done} !== ctrl_exp) begin
        miscompares++;
        $display("[TB] FAIL b2b_ctrl c=%0d: got %b expected %b",
                 c, {in_ready, acc_rst, shift_en, acc_en, tile_done}, ctrl_exp);
      end
      vectors++;
      if (left_out !== a_exp || top_out !== b_exp) begin
        miscompares++;
        $display("[TB] FAIL b2b_lanes c=%0d: left=%h top=%h expected %h %h",
                 c, left_out, top_out, a_exp, b_exp);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_n1;
    logic [4:0] ctrl_exp;
    for (int c = 0; c < 7; c++) begin
      in_valid1 = (c <= 2);
      in_last1  = (c == 2);
      in_a1     = (c == 2) ? 8'h5A : 8'hFF;
      in_b1     = (c == 2) ? 8'hA5 : 8'hFF;
      @(negedge clk);
      ctrl_exp = {(c == 2), (c == 1), (c == 3), (c == 3), (c == 3)};
      vectors++;
      if ({in_ready1, acc_rst1, shift_en1, acc_en1, tile_done1} !== ctrl_exp) begin
        miscompares++;
        $display("[TB] FAIL n1_ctrl c=%0d: got %b expected %b",
                 c, {in_ready1, acc_rst1, shift_en1, acc_en1, tile_done1}, ctrl_exp);
      end
      vectors++;
      if (left_out1 !== ((c >= 3) ? 8'h5A : 8'h00) || top_out1 !== ((c >= 3) ? 8'hA5 : 8'h00)) begin
        miscompares++;
        $display("[TB] FAIL n1_lanes c=%0d: left=%h top=%h", c, left_out1, top_out1);
      end
      @(posedge clk); #1;
    end
    in_valid1 = 1'b0;
    in_last1  = 1'b0;
  endtask

`ifdef SKEW_FEEDER_BEAT_COUNT_EN
  task automatic test_beat_count;
    logic [15:0] cnt_exp;
    for (int c = 0; c < 26; c++) begin
      in_valid = (c <= 6) || (c == 15) || (c == 17);
      in_last  = (c == 6) || (c == 17);
      in_a     = beat_vec(clampi(c - 2, 0, 4), 1'b0);
      in_b     = beat_vec(clampi(c - 2, 0, 4), 1'b1);
      @(negedge clk);
      cnt_exp = (c <= 15) ? 16'(clampi(c - 2, 0, 5)) : ((c <= 17) ? 16'd0 : 16'd1);
      if (c >= 1) begin
        vectors++;
        if (beat_count !== cnt_exp) begin
          miscompares++;
          $display("[TB] FAIL beat_count c=%0d: got %0d expected %0d", c, beat_count, cnt_exp);
        end
      end
      vectors++;
      if (tile_done !== (c == 13 || c == 24)) begin
        miscompares++;
        $display("[TB] FAIL beat_count_done c=%0d: got %b", c, tile_done);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask
`endif

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_valid1 = 1'b0;
    in_last1  = 1'b0;
    in_a1     = '0;
    in_b1     = '0;
    test_reset;
    test_gapless;
    test_bubble;
    test_back_to_back;
    test_n1;
`ifdef SKEW_FEEDER_BEAT_COUNT_EN
    test_beat_count;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
